// File: rtl/ble_cmd_controller.sv
// -----------------------------------------------------------------------------
// ble_cmd_controller
//   Parses Bluefruit control-pad packets "!B<btn><0|1><csum>" from the UART
//   byte stream and validates the checksum. The checksum byte brings the
//   8-bit sum of all five bytes to 8'hFF. Accepted packets update a set of
//   pending button levels. The pending levels are committed to the gameplay
//   outputs only on new_frame_in, so gameplay sees inputs that stay constant
//   for a whole frame. Single clock domain (pixel clock).
//
// Ports
//   clk_in            in   1  pixel clock
//   rst_in            in   1  synchronous, active-high reset
//   byte_in           in   8  received UART byte
//   byte_valid_in     in   1  one-cycle strobe: byte_in valid
//   new_frame_in      in   1  one-cycle frame strobe
//   charging_hit_out  out  1  held level: hit button pressed
//   pan_left_out      out  1  held level: camera pan left
//   pan_right_out     out  1  held level: camera pan right
//   new_game_out      out  1  one-cycle pulse: start a new game
//   last_btn_out      out  4  low nibble of the last accepted button code
//   pkt_err_out       out  1  one-cycle pulse: packet dropped
// -----------------------------------------------------------------------------
module ble_cmd_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 742_500,
  parameter logic [7:0]  HIT_BTN        = 8'h31,
  parameter logic [7:0]  RESET_BTN      = 8'h34,
  parameter logic [7:0]  LEFT_BTN       = 8'h37,
  parameter logic [7:0]  RIGHT_BTN      = 8'h38
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  input  logic       new_frame_in,
  output logic       charging_hit_out,
  output logic       pan_left_out,
  output logic       pan_right_out,
  output logic       new_game_out,
  output logic [3:0] last_btn_out,
  output logic       pkt_err_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR_B = 3'd1;
  localparam logic [2:0] BTN   = 3'd2;
  localparam logic [2:0] PRESS = 3'd3;
  localparam logic [2:0] CSUM  = 3'd4;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SOF_BYTE = 8'h21;  // '!'
  localparam logic [7:0] TYP_BYTE = 8'h42;  // 'B'

  logic [2:0]       state_q, state_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       btn_q, btn_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_hit_q, pend_hit_d;
  logic             pend_left_q, pend_left_d;
  logic             pend_right_q, pend_right_d;
  logic             pend_ng_q, pend_ng_d;
  logic             hit_q, hit_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             ng_q, ng_d;
  logic [3:0]       last_btn_q, last_btn_d;
  logic             err_q, err_d;

  logic [7:0] sum_next;
  logic       bad_byte;
  logic       accept;

  assign sum_next = sum_q + byte_in;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    sum_d        = sum_q;
    btn_d        = btn_q;
    press_d      = press_q;
    cnt_d        = cnt_q;
    pend_hit_d   = pend_hit_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_ng_d    = pend_ng_q;
    hit_d        = hit_q;
    left_d       = left_q;
    right_d      = right_q;
    ng_d         = 1'b0;
    last_btn_d   = last_btn_q;
    err_d        = 1'b0;
    bad_byte     = 1'b0;
    accept       = 1'b0;

    // A byte always wins over a timeout expiring in the same cycle.
    if (byte_valid_in) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (byte_in == SOF_BYTE) begin
            state_d = HDR_B;
            sum_d   = SOF_BYTE;
          end
        end
        HDR_B: begin
          if (byte_in == TYP_BYTE) begin
            state_d = BTN;
            sum_d   = sum_next;
          end else begin
            bad_byte = 1'b1;
          end
        end
        BTN: begin
          if (byte_in >= 8'h31 && byte_in <= 8'h38) begin
            state_d = PRESS;
            btn_d   = byte_in;
            sum_d   = sum_next;
          end else begin
            bad_byte = 1'b1;
          end
        end
        PRESS: begin
          if (byte_in == 8'h30 || byte_in == 8'h31) begin
            state_d = CSUM;
            press_d = byte_in[0];
            sum_d   = sum_next;
          end else begin
            bad_byte = 1'b1;
          end
        end
        CSUM: begin
          // '!' here is just a checksum value, never a restart.
          state_d = IDLE;
          if (sum_next == 8'hFF) accept = 1'b1;
          else                   err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // A stray '!' mid-packet most likely starts the next packet.
      if (bad_byte) begin
        err_d = 1'b1;
        if (byte_in == SOF_BYTE) begin
          state_d = HDR_B;
          sum_d   = SOF_BYTE;
        end else begin
          state_d = IDLE;
        end
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Commit uses the pending values registered before this cycle, so a
    // packet accepted in the same cycle lands on the following frame.
    if (new_frame_in) begin
      hit_d     = pend_hit_q;
      left_d    = pend_left_q;
      right_d   = pend_right_q;
      ng_d      = pend_ng_q;
      pend_ng_d = 1'b0;
    end

    // Placed after the commit so a same-cycle reset press survives the clear.
    if (accept) begin
      last_btn_d = btn_q[3:0];
      if (btn_q == HIT_BTN)   pend_hit_d   = press_q;
      if (btn_q == LEFT_BTN)  pend_left_d  = press_q;
      if (btn_q == RIGHT_BTN) pend_right_d = press_q;
      if (btn_q == RESET_BTN && press_q) pend_ng_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q      <= IDLE;
      sum_q        <= '0;
      btn_q        <= '0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
      pend_hit_q   <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_ng_q    <= 1'b0;
      hit_q        <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      ng_q         <= 1'b0;
      last_btn_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      btn_q        <= btn_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
      pend_hit_q   <= pend_hit_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_ng_q    <= pend_ng_d;
      hit_q        <= hit_d;
      left_q       <= left_d;
      right_q      <= right_d;
      ng_q         <= ng_d;
      last_btn_q   <= last_btn_d;
      err_q        <= err_d;
    end
  end

  assign charging_hit_out = hit_q;
  assign pan_left_out     = left_q;
  assign pan_right_out    = right_q;
  assign new_game_out     = ng_q;
  assign last_btn_out     = last_btn_q;
  assign pkt_err_out      = err_q;

endmodule
